// File: rtl/moving_sum_cplx.sv
// moving_sum_cplx
//   Complex sliding-window accumulator for the OFDM synchronisation path.
//   It keeps the last WIN accepted samples in a circular delay line and
//   maintains a running sum: sum += new - oldest. While the window is filling
//   (FILL), the oldest sample is ignored, so the delay line never needs
//   clearing.
//
// Parameters
//   DW  : signed width of each input component
//   WIN : window length in samples (2..1024, any integer)
//   AW  : pointer width, derived -- do not override
//   SW  : sum width, derived so the sum cannot overflow -- do not override
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset (same effect as clr)
//   ena            : input sample valid, one sample per cycle
//   clr            : synchronous window restart, priority over ena
//   din_Re/din_Im  : signed input sample
//   sum_Re/sum_Im  : registered signed window sum
//   sum_vld        : pulse, the sum was updated on the previous edge
//   full           : window holds WIN samples (state RUN)
module moving_sum_cplx #(
  parameter int DW  = 16,
  parameter int WIN = 64,
  parameter int AW  = $clog2(WIN),
  parameter int SW  = DW + $clog2(WIN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 clr,
  input  logic signed [DW-1:0] din_Re,
  input  logic signed [DW-1:0] din_Im,
  output logic signed [SW-1:0] sum_Re,
  output logic signed [SW-1:0] sum_Im,
  output logic                 sum_vld,
  output logic                 full
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] x);
    return {{(SW-DW){x[DW-1]}}, x};
  endfunction

  logic signed [DW-1:0] mem_re [WIN];
  logic signed [DW-1:0] mem_im [WIN];

  logic [0:0]           state_p1;
  logic [AW-1:0]        wr_ptr_p1;
  logic [AW:0]          cnt_p1;
  logic signed [SW-1:0] sum_re_p1;
  logic signed [SW-1:0] sum_im_p1;
  logic                 vld_p1;

  logic                 accept_p0;
  logic signed [DW-1:0] old_re_p0;
  logic signed [DW-1:0] old_im_p0;
  logic signed [SW-1:0] sub_re_p0;
  logic signed [SW-1:0] sub_im_p0;
  logic signed [SW-1:0] nxt_re_p0;
  logic signed [SW-1:0] nxt_im_p0;

  // ---- stage p0: read oldest sample, form next sum ----
  assign accept_p0 = ena & ~clr & ~rst;
  assign old_re_p0 = mem_re[wr_ptr_p1];
  assign old_im_p0 = mem_im[wr_ptr_p1];
  // During FILL the slot under the pointer holds stale data, so it is not subtracted.
  assign sub_re_p0 = (state_p1 == RUN) ? sext(old_re_p0) : '0;
  assign sub_im_p0 = (state_p1 == RUN) ? sext(old_im_p0) : '0;
  assign nxt_re_p0 = sum_re_p1 + sext(din_Re) - sub_re_p0;
  assign nxt_im_p0 = sum_im_p1 + sext(din_Im) - sub_im_p0;

  // ---- stage p1: delay line write ----
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      mem_re[wr_ptr_p1] <= din_Re;
      mem_im[wr_ptr_p1] <= din_Im;
    end
  end

  // ---- stage p1: sum, pointer, fill tracking ----
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_p1  <= FILL;
      wr_ptr_p1 <= '0;
      cnt_p1    <= '0;
      sum_re_p1 <= '0;
      sum_im_p1 <= '0;
      vld_p1    <= 1'b0;
    end else if (ena) begin
      sum_re_p1 <= nxt_re_p0;
      sum_im_p1 <= nxt_im_p0;
      vld_p1    <= 1'b1;
      wr_ptr_p1 <= (wr_ptr_p1 == AW'(WIN-1)) ? '0 : wr_ptr_p1 + AW'(1);
      if (state_p1 == FILL) begin
        cnt_p1 <= cnt_p1 + (AW+1)'(1);
        if (cnt_p1 == (AW+1)'(WIN-1)) state_p1 <= RUN;
      end
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign sum_Re  = sum_re_p1;
  assign sum_Im  = sum_im_p1;
  assign sum_vld = vld_p1;
  assign full    = (state_p1 == RUN);

endmodule

// File: tb/tb_moving_sum_cplx.sv
// tb_moving_sum_cplx
//   Directed bench for moving_sum_cplx. Instance u4 uses WIN=4, DW=16 (SW=18)
//   for fill/slide, extremes, gapped enable, clr and reset scenarios; instance
//   u5 uses WIN=5 (SW=19) for pointer wrap on a non-power-of-two window.
module tb_moving_sum_cplx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               ena4 = 1'b0, clr4 = 1'b0;
  logic signed [15:0] re4 = '0, im4 = '0;
  logic signed [17:0] s4_re, s4_im;
  logic               vld4, full4;

  logic               ena5 = 1'b0, clr5 = 1'b0;
  logic signed [15:0] re5 = '0, im5 = '0;
  logic signed [18:0] s5_re, s5_im;
  logic               vld5, full5;

  int n_chk  = 0;
  int n_fail = 0;

  moving_sum_cplx #(.DW(16), .WIN(4)) u4 (
    .clk(clk), .rst(rst), .ena(ena4), .clr(clr4),
    .din_Re(re4), .din_Im(im4),
    .sum_Re(s4_re), .sum_Im(s4_im), .sum_vld(vld4), .full(full4)
  );

  moving_sum_cplx #(.DW(16), .WIN(5)) u5 (
    .clk(clk), .rst(rst), .ena(ena5), .clr(clr5),
    .din_Re(re5), .din_Im(im5),
    .sum_Re(s5_re), .sum_Im(s5_im), .sum_vld(vld5), .full(full5)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input longint e_re, input longint e_im,
                      input longint e_vld, input longint e_full);
    chk({tag, "_re"},   s4_re, e_re);
    chk({tag, "_im"},   s4_im, e_im);
    chk({tag, "_vld"},  vld4,  e_vld);
    chk({tag, "_full"}, full4, e_full);
  endtask

  // Present one cycle of stimulus to u4, then sample 1 time unit after the edge.
  task automatic step4(input logic e, input logic c, input int re, input int im);
    ena4 = e; clr4 = c; re4 = 16'(re); im4 = 16'(im);
    @(posedge clk); #1;
    ena4 = 1'b0; clr4 = 1'b0;
  endtask

  initial begin
    int fill_exp[6];
    int pos_exp[4];
    int gap_exp[3];
    fill_exp = '{1, 3, 6, 10, 14, 18};
    pos_exp  = '{-65537, -2, 65533, 131068};
    gap_exp  = '{6, 10, 14};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk4("reset", 0, 0, 0, 0);
    chk("reset5_re", s5_re, 0);
    chk("reset5_full", full5, 0);
    rst = 1'b0;

    // Fill and slide: Re 1..6, Im mirrors with opposite sign
    for (int i = 0; i < 6; i++) begin
      step4(1'b1, 1'b0, i + 1, -(i + 1));
      chk4($sformatf("fill%0d", i), fill_exp[i], -fill_exp[i], 1, (i >= 3) ? 1 : 0);
    end
    step4(1'b0, 1'b0, 55, 55);
    chk4("idle_hold", 18, -18, 0, 1);

    // clr together with ena: sample 99 discarded
    step4(1'b1, 1'b1, 99, 99);
    chk4("clr", 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step4(1'b1, 1'b0, 7, -7);
      chk4($sformatf("refill7_%0d", k), 7 * k, -7 * k, 1, (k == 4) ? 1 : 0);
    end

    // Extremes on Im
    step4(1'b0, 1'b1, 0, 0);
    chk4("clr_ext", 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step4(1'b1, 1'b0, 0, -32768);
      chk4($sformatf("neg%0d", k), 0, -32768 * k, 1, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      step4(1'b1, 1'b0, 0, 32767);
      chk4($sformatf("pos%0d", k), 0, pos_exp[k], 1, 1);
    end

    // Gapped enable
    step4(1'b0, 1'b1, 0, 0);
    step4(1'b1, 1'b0, 1, 0);
    chk4("gap_a1", 1, 0, 1, 0);
    step4(1'b1, 1'b0, 2, 0);
    chk4("gap_a2", 3, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step4(1'b0, 1'b0, 77, 77);
      chk4($sformatf("gap_idle%0d", k), 3, 0, 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step4(1'b1, 1'b0, k + 3, 0);
      chk4($sformatf("gap_b%0d", k), gap_exp[k], 0, 1, (k >= 1) ? 1 : 0);
    end

    // Reset mid-run, with a sample presented that must be ignored
    ena4 = 1'b1; re4 = 16'sd50; im4 = 16'sd50; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ena4 = 1'b0;
    chk4("rst_mid", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step4(1'b1, 1'b0, i + 1, -(i + 1));
      chk4($sformatf("rfill%0d", i), fill_exp[i], -fill_exp[i], 1, (i >= 3) ? 1 : 0);
    end

    // Wrap stress on WIN=5: stream 0..19, each output is the sum of the last 5 inputs
    for (int i = 0; i < 20; i++) begin
      int e_re;
      e_re = 0;
      for (int j = ((i > 4) ? i - 4 : 0); j <= i; j++) e_re += j;
      ena5 = 1'b1; re5 = 16'(i); im5 = 16'(-3 * i);
      @(posedge clk); #1;
      ena5 = 1'b0;
      chk($sformatf("wrap%0d_re", i), s5_re, e_re);
      chk($sformatf("wrap%0d_im", i), s5_im, -3 * e_re);
      chk($sformatf("wrap%0d_vld", i), vld5, 1);
      chk($sformatf("wrap%0d_full", i), full5, (i >= 4) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
